// File: rtl/subtractor9_pipe.sv
// Two-stage 8-bit subtractor (a + ~b + 1) with a valid/ready handshake and Kogge-Stone carries.
// Build option: define SUB9_SATURATE_EN to clamp diff to 0x00 whenever borrow_out is set.
module subtractor9_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;

    logic [WIDTH-1:0] bit_g;
    logic [WIDTH-1:0] bit_p;
    logic [1:0]       grp_g;
    logic [1:0]       grp_p;

    // Group index 0 covers bits 3:0, index 1 covers bits 7:4.
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic [1:0]       s1_grp_g;
    logic [1:0]       s1_grp_p;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] raw_diff;
    logic [WIDTH-1:0] next_diff;
    logic             next_borrow;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Stage 1: bitwise generate/propagate of a + ~b, then a 2-level prefix per nibble.
    always_comb begin
        logic [3:0] kg;
        logic [3:0] kp;
        kg    = '0;
        kp    = '0;
        bit_g = a_in & ~b_in;
        bit_p = a_in ^ ~b_in;
        grp_g = '0;
        grp_p = '0;
        for (int n = 0; n < 2; n++) begin
            kg = bit_g[4*n +: 4];
            kp = bit_p[4*n +: 4];
            for (int d = 1; d < 4; d = d * 2) begin
                for (int i = 3; i >= d; i--) begin
                    kg[i] = kg[i] | (kp[i] & kg[i-d]);
                    kp[i] = kp[i] & kp[i-d];
                end
            end
            grp_g[n] = kg[3];
            grp_p[n] = kp[3];
        end
    end

    // Stage 2: intra-nibble prefixes for the low three bits, group terms bridge the nibbles.
    always_comb begin
        logic [2:0] kg;
        logic [2:0] kp;
        kg       = '0;
        kp       = '0;
        carry    = '0;
        carry[0] = 1'b1;
        for (int n = 0; n < 2; n++) begin
            kg = s1_g[4*n +: 3];
            kp = s1_p[4*n +: 3];
            for (int d = 1; d < 3; d = d * 2) begin
                for (int i = 2; i >= d; i--) begin
                    kg[i] = kg[i] | (kp[i] & kg[i-d]);
                    kp[i] = kp[i] & kp[i-d];
                end
            end
            for (int i = 0; i < 3; i++) begin
                carry[4*n+i+1] = kg[i] | (kp[i] & carry[4*n]);
            end
            carry[4*n+4] = s1_grp_g[n] | (s1_grp_p[n] & carry[4*n]);
        end
        raw_diff    = s1_p ^ carry[WIDTH-1:0];
        next_borrow = ~carry[WIDTH];
`ifdef SUB9_SATURATE_EN
        next_diff   = next_borrow ? '0 : raw_diff;
`else
        next_diff   = raw_diff;
`endif
    end

    // Top-of-nibble generates only matter through the registered group terms.
    logic unused_top_g;
    assign unused_top_g = s1_g[3] ^ s1_g[7];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_valid   <= 1'b0;
            s1_g       <= '0;
            s1_p       <= '0;
            s1_grp_g   <= '0;
            s1_grp_p   <= '0;
            s2_valid   <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_g     <= bit_g;
                    s1_p     <= bit_p;
                    s1_grp_g <= grp_g;
                    s1_grp_p <= grp_p;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    diff       <= next_diff;
                    borrow_out <= next_borrow;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A stalled result must stay put until the consumer takes it.
    stall_hold_a: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        (out_valid && !out_ready) |=> (out_valid && $stable(diff) && $stable(borrow_out)));
`endif

endmodule

// File: tb/tb_subtractor9_pipe.sv
// Scoreboard bench for subtractor9_pipe: directed boundary/stall/reset cases plus random traffic.
// Expected results come from plain integer subtraction; SUB9_SATURATE_EN selects the clamped model.
module tb_subtractor9_pipe;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       in_valid   = 1'b0;
    logic       out_ready  = 1'b0;
    logic [7:0] a_in       = 8'h00;
    logic [7:0] b_in       = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       borrow_out;
    logic [7:0] diff;

    int         n_checks     = 0;
    int         n_fail       = 0;
    int         cyc          = 0;
    int         out_count    = 0;
    int         gaps         = 0;
    int         last_out_cyc = -1;
    bit         track        = 1'b0;
    bit         rand_phase   = 1'b0;
    logic [8:0] exp_q[$];
    logic       stall_prev   = 1'b0;
    logic [8:0] held         = '0;

    subtractor9_pipe #(.WIDTH(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
        int         d;
        logic       br;
        logic [7:0] r;
        d  = int'(a) - int'(b);
        br = (d < 0);
        r  = 8'((d + 256) % 256);
`ifdef SUB9_SATURATE_EN
        if (br) r = 8'h00;
`endif
        return {br, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Input side: an operand pair seen valid/ready before an edge is a transfer at that edge.
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(ref_sub(a_in, b_in));
    end

    // Output side: pop and compare on each output transfer; check held data while stalled.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", {borrow_out, diff}, held);
            end
            if (out_valid && out_ready) begin
                out_count++;
                if (track) begin
                    if (last_out_cyc >= 0 && cyc != last_out_cyc + 1) gaps++;
                    last_out_cyc = cyc;
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", {borrow_out, diff});
                end else begin
                    e = exp_q.pop_front();
                    n_checks--;
                    check("result", {borrow_out, diff}, e);
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {borrow_out, diff};
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, output int tries);
        logic acc;
        acc   = 1'b0;
        tries = 0;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        while (!acc && tries < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          tries;
        int          acc;
        int          base;
        int          t;
        logic [15:0] pairs[3];
        pairs = '{16'h3112, 16'h4041, 16'h9909};

        // Reset state, including in_ready while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", diff, 0);
        check("reset_borrow", borrow_out, 0);
        check("reset_in_ready", in_ready, 1);
        rst       = 1'b0;
        out_ready = 1'b1;

        // First input accepted immediately; result two cycles after transfer.
        send(8'h5A, 8'h23, tries);
        check("first_accept_tries", tries, 1);
        check("latency_not_early", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_valid", out_valid, 1);
        check("latency_result", {borrow_out, diff}, 9'h037);
        @(posedge clk);
        #1;

        send(8'h10, 8'h20, tries);
        @(posedge clk);
        #1;
`ifdef SUB9_SATURATE_EN
        check("sub_10_20", {borrow_out, diff}, 9'h100);
`else
        check("sub_10_20", {borrow_out, diff}, 9'h1F0);
`endif

        // Boundaries through the scoreboard.
        send(8'h00, 8'hFF, tries);
        send(8'hFF, 8'h00, tries);
        send(8'h77, 8'h77, tries);
        send(8'h00, 8'h00, tries);
        send(8'hFF, 8'hFF, tries);
        send(8'h80, 8'h81, tries);
        drain();

        // Back-to-back stream: 256 results on consecutive cycles.
        base         = out_count;
        gaps         = 0;
        last_out_cyc = -1;
        track        = 1'b1;
        for (int i = 0; i < 256; i++) send(8'(i), 8'(255 - i), tries);
        drain();
        track = 1'b0;
        check("stream_count", out_count - base, 256);
        check("stream_gaps", gaps, 0);

        // Stall: three offered with out_ready low, only two fit.
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        {a_in, b_in} = pairs[0];
        repeat (4) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            if (acc < 3) {a_in, b_in} = pairs[acc];
        end
        check("stall_accepted", acc, 2);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_head", {borrow_out, diff}, ref_sub(8'h31, 8'h12));
        out_ready = 1'b1;
        acc = 0;
        t   = 0;
        while (acc == 0 && t < 10) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        check("third_accepted", acc, 1);
        drain();

        // Reset with two results in flight discards both.
        out_ready = 1'b0;
        send(8'h12, 8'h34, tries);
        send(8'h56, 8'h07, tries);
        check("flight_full", in_ready, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_diff", diff, 0);
        check("flush_borrow", borrow_out, 0);
        check("flush_in_ready", in_ready, 1);
        base = out_count;
        rst  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("flush_no_stale", out_count - base, 0);

        // Random traffic with random backpressure.
        rand_phase = 1'b1;
        fork
            begin
                while (rand_phase) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join_none
        base = out_count;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(8'($urandom), 8'($urandom), tries);
        end
        rand_phase = 1'b0;
        @(posedge clk);
        #1;
        drain();
        check("random_count", out_count - base, 10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
